// File: rtl/operand_route_pkg.sv
// Shared constants and types for the registered operand-source router.
// Opcodes, FSM state type and the word-count helper live here.
package operand_route_pkg;

    localparam int WIDTH_D = 1506;
    localparam int N_SRC_D = 5;
    localparam int IN_W_D  = 64;
    localparam int SEL_W_D = 3;

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_DIN   = 3'd1;
    localparam logic [2:0] OP_DOUTA = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_SRC,
        ST_HOLD
    } state_t;

    // Number of load words needed to cover one operand.
    function automatic int nw_calc(input int width, input int in_w);
        return (width + in_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/operand_word_asm.sv
// Word-indexed assembly register for external operand loads.
// Words arrive least-significant first; the last word is truncated to WIDTH.
module operand_word_asm
    import operand_route_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int IN_W  = IN_W_D,
    parameter int NW    = nw_calc(WIDTH, IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [IN_W-1:0]  word,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    logic [CW-1:0] count;

    assign last = (count == CW'(NW - 1));

    // Word counter: restarts on clear and after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

    for (genvar w = 0; w < NW; w++) begin : g_word
        localparam int LO   = w * IN_W;
        localparam int BITS = (WIDTH - LO < IN_W) ? (WIDTH - LO) : IN_W;

        logic [BITS-1:0] seg;

        // One segment per word slot; the top slot keeps only its in-range bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seg <= '0;
            end else if (clr) begin
                seg <= '0;
            end else if (wr && count == CW'(w)) begin
                seg <= word[BITS-1:0];
            end
        end

        assign data[LO +: BITS] = seg;
    end

endmodule

// File: rtl/operand_route_reg.sv
// Registered, handshaked operand-source router for the field datapath.
// Picks a result bus, zero, or an assembled external load per instruction.
module operand_route_reg
    import operand_route_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int N_SRC = N_SRC_D,
    parameter int IN_W  = IN_W_D,
    parameter int SEL_W = SEL_W_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_in,
    input  logic [SEL_W-1:0]       ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    input  logic [IN_W-1:0]        ld_word,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int NW        = nw_calc(WIDTH, IN_W);
    localparam int LAST_LO   = (NW - 1) * IN_W;
    localparam int LAST_BITS = WIDTH - LAST_LO;

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] idx;
    logic             is_src;
    logic             accept;
    logic             ld_fire;
    logic             data_we;
    logic [WIDTH-1:0] data_nx;
    logic             asm_clr;
    logic             asm_last;
    logic [WIDTH-1:0] asm_data;
    logic [WIDTH-1:0] load_full;

    assign ins_ready = (state == ST_IDLE) ||
                       (state == ST_HOLD && out_ready);
    assign ld_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign accept    = ins_valid && ins_ready;
    assign ld_fire   = ld_valid && ld_ready;

    assign idx    = ins - SEL_W'(1);
    assign is_src = (ins != SEL_W'(OP_ZERO)) &&
                    (ins <= SEL_W'(N_SRC));

    operand_word_asm #(
        .WIDTH (WIDTH),
        .IN_W  (IN_W),
        .NW    (NW)
    ) u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (asm_clr),
        .wr    (ld_fire),
        .word  (ld_word),
        .data  (asm_data),
        .last  (asm_last)
    );

    // Merge the final word in directly so the operand is ready one cycle after it.
    always_comb begin
        load_full = asm_data;
        load_full[WIDTH-1:LAST_LO] = ld_word[LAST_BITS-1:0];
    end

    // Next state, source selection and output-register load control.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        data_we  = 1'b0;
        data_nx  = '0;
        asm_clr  = 1'b0;
        unique case (state)
            ST_IDLE, ST_HOLD: begin
                if (state == ST_HOLD && out_ready) begin
                    state_nx = ST_IDLE;
                end
                if (accept) begin
                    if (d_in) begin
                        state_nx = ST_LOAD;
                        asm_clr  = 1'b1;
                    end else if (!is_src) begin
                        state_nx = ST_HOLD;
                        data_we  = 1'b1;
                    end else if (src_valid[idx]) begin
                        state_nx = ST_HOLD;
                        data_we  = 1'b1;
                        data_nx  = src_data[idx*WIDTH +: WIDTH];
                    end else begin
                        state_nx = ST_WAIT_SRC;
                        sel_nx   = idx;
                    end
                end
            end
            ST_LOAD: begin
                if (ld_fire && asm_last) begin
                    state_nx = ST_HOLD;
                    data_we  = 1'b1;
                    data_nx  = load_full;
                end
            end
            ST_WAIT_SRC: begin
                if (src_valid[sel]) begin
                    state_nx = ST_HOLD;
                    data_we  = 1'b1;
                    data_nx  = src_data[sel*WIDTH +: WIDTH];
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, pending source index and output operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            if (data_we) begin
                out_data <= data_nx;
            end
        end
    end

endmodule

// File: tb/tb_operand_route_reg.sv
// Bench for operand_route_reg: vector table, directed corners, random stress.
// Expected operands come from a transaction-level model of the routing rules.
module tb_operand_route_reg;

    localparam int W  = 1506;
    localparam int NS = 5;
    localparam int IW = 64;
    localparam int NW = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              d_in;
    logic [2:0]        ins;
    logic              ins_valid;
    logic              ins_ready;
    logic [IW-1:0]     ld_word;
    logic              ld_valid;
    logic              ld_ready;
    logic [NS*W-1:0]   src_data;
    logic [NS-1:0]     src_valid;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    operand_route_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ld_word   (ld_word),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .src_data  (src_data),
        .src_valid (src_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", nm,
                     act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, W'(act), W'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [48*32-1:0] t;
        for (int i = 0; i < 48; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic set_src(input int k, input logic [W-1:0] v);
        src_data[k*W +: W] = v;
    endtask

    typedef struct {
        logic [2:0]    ins;
        logic [NS-1:0] sv;
        logic [31:0]   exp;
    } vec_t;

    // Transaction-level reference model state
    bit              m_building;
    bit              m_is_load;
    bit              m_holding;
    int              m_pend;
    int              m_wcnt;
    logic [NW*IW-1:0] m_acc;
    logic [W-1:0]    m_hold;
    int              produced;
    int              consumed;
    int              accepted;

    // One clock of stimulus already applied: check outputs, then advance model.
    task automatic cycle_model();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !m_building && (!m_holding || out_ready);
        chk1("rnd_ins_ready", ins_ready, exp_rdy);
        chk1("rnd_out_valid", out_valid, m_holding);
        chk1("rnd_ld_ready", ld_ready, m_building && m_is_load);
        chk1("rnd_busy", busy, m_building || m_holding);
        if (m_holding) chk("rnd_out_data", out_data, m_hold);
        if (m_holding && out_ready) begin
            consumed++;
            m_holding = 0;
        end
        if (m_building) begin
            if (m_is_load) begin
                if (ld_valid) begin
                    m_acc[m_wcnt*IW +: IW] = ld_word;
                    m_wcnt++;
                    if (m_wcnt == NW) begin
                        m_hold = m_acc[W-1:0];
                        m_holding = 1;
                        m_building = 0;
                        produced++;
                    end
                end
            end else if (src_valid[m_pend]) begin
                m_hold = src_data[m_pend*W +: W];
                m_holding = 1;
                m_building = 0;
                produced++;
            end
        end else if (ins_valid && exp_rdy) begin
            accepted++;
            if (d_in) begin
                m_building = 1;
                m_is_load = 1;
                m_wcnt = 0;
                m_acc = '0;
            end else if (ins == 3'd0 || ins > 3'd5) begin
                m_hold = '0;
                m_holding = 1;
                produced++;
            end else if (src_valid[int'(ins) - 1]) begin
                m_hold = src_data[(int'(ins) - 1)*W +: W];
                m_holding = 1;
                produced++;
            end else begin
                m_building = 1;
                m_is_load = 0;
                m_pend = int'(ins) - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t             vecs[9];
        logic [W-1:0]     exp_w;
        logic [NW*IW-1:0] wide;

        vecs[0] = '{3'd0, 5'b00000, 32'h0};
        vecs[1] = '{3'd1, 5'b00001, 32'h1111_0000};
        vecs[2] = '{3'd2, 5'b00010, 32'h1111_0001};
        vecs[3] = '{3'd3, 5'b00100, 32'h1111_0002};
        vecs[4] = '{3'd4, 5'b01000, 32'h1111_0003};
        vecs[5] = '{3'd5, 5'b10000, 32'h1111_0004};
        vecs[6] = '{3'd6, 5'b11111, 32'h0};
        vecs[7] = '{3'd7, 5'b11111, 32'h0};
        vecs[8] = '{3'd2, 5'b11111, 32'h1111_0001};

        rst_n = 1'b0;
        d_in = 0; ins = '0; ins_valid = 0;
        ld_word = '0; ld_valid = 0;
        src_data = '0; src_valid = '0;
        out_ready = 0;
        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ins_ready", ins_ready, 1'b1);
        chk1("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-cycle selections from IDLE
        for (int k = 0; k < NS; k++) set_src(k, W'(32'h1111_0000 + k));
        for (int i = 0; i < 9; i++) begin
            ins_valid = 1; ins = vecs[i].ins;
            src_valid = vecs[i].sv; out_ready = 0;
            #1;
            chk1("vec_ins_ready", ins_ready, 1'b1);
            tick();
            ins_valid = 0; src_valid = '0;
            chk1("vec_out_valid", out_valid, 1'b1);
            chk("vec_out_data", out_data, W'(vecs[i].exp));
            out_ready = 1;
            tick();
            out_ready = 0;
            chk1("vec_release", out_valid, 1'b0);
        end

        // Hold stability while the captured bus keeps changing
        set_src(2, W'(32'h1234));
        ins_valid = 1; ins = 3'd3; src_valid = 5'b00100;
        tick();
        ins_valid = 0;
        chk("hold_first", out_data, W'(32'h1234));
        for (int c = 0; c < 4; c++) begin
            set_src(2, rand_wide());
            src_valid = 5'b11111;
            tick();
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, W'(32'h1234));
        end
        src_valid = '0; out_ready = 1;
        tick();
        out_ready = 0;

        // Wait six cycles for source 5, with decoys on other buses
        set_src(4, W'(32'h9999));
        ins_valid = 1; ins = 3'd5; src_valid = '0;
        tick();
        ins_valid = 0;
        for (int c = 0; c < 6; c++) begin
            src_valid = 5'b01111;
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_out_valid", out_valid, 1'b0);
            chk1("wait_ins_ready", ins_ready, 1'b0);
            tick();
        end
        set_src(4, W'(32'hABCD));
        src_valid = 5'b10000;
        tick();
        src_valid = '0;
        chk1("wait_done_valid", out_valid, 1'b1);
        chk("wait_done_data", out_data, W'(32'hABCD));
        out_ready = 1;
        tick();
        out_ready = 0;

        // External load: words i+1 with a gap, opcode ignored
        ins_valid = 1; d_in = 1; ins = 3'd3; src_valid = 5'b00100;
        tick();
        ins_valid = 0; d_in = 0; src_valid = '0;
        chk1("load_ld_ready", ld_ready, 1'b1);
        wide = '0;
        for (int i = 0; i < NW; i++) begin
            if (i == 12) begin
                ld_valid = 0;
                repeat (3) tick();
                chk1("load_gap_ready", ld_ready, 1'b1);
            end
            ld_valid = 1; ld_word = IW'(i + 1);
            wide[i*IW +: IW] = IW'(i + 1);
            if (i == NW - 1) chk1("load_pre_valid", out_valid, 1'b0);
            tick();
        end
        ld_valid = 0;
        chk1("load_valid", out_valid, 1'b1);
        chk("load_data", out_data, wide[W-1:0]);
        out_ready = 1;
        tick();
        out_ready = 0;

        // External load of all-ones: top word must be truncated
        ins_valid = 1; d_in = 1;
        tick();
        ins_valid = 0; d_in = 0;
        ld_valid = 1; ld_word = '1;
        repeat (NW) tick();
        ld_valid = 0;
        exp_w = '1;
        chk("load_trunc", out_data, exp_w);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Back-to-back handoff without a bubble
        set_src(0, W'(32'h5555));
        set_src(1, W'(32'h6666));
        ins_valid = 1; ins = 3'd1; src_valid = 5'b00001;
        tick();
        ins = 3'd2; src_valid = 5'b00010; out_ready = 1;
        #1;
        chk1("b2b_ins_ready", ins_ready, 1'b1);
        tick();
        chk1("b2b_valid", out_valid, 1'b1);
        chk("b2b_data", out_data, W'(32'h6666));
        ins = 3'd4; src_valid = '0;
        tick();
        ins_valid = 0; out_ready = 0;
        chk1("b2b_bubble", out_valid, 1'b0);
        chk1("b2b_wait_busy", busy, 1'b1);

        // Asynchronous reset in the middle of a source wait
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ins_ready", ins_ready, 1'b1);
        chk("arst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        src_valid = 5'b01000;
        tick();
        tick();
        src_valid = '0;
        chk1("arst_no_output", out_valid, 1'b0);

        // Asynchronous reset in the middle of a load
        ins_valid = 1; d_in = 1;
        tick();
        ins_valid = 0; d_in = 0;
        ld_valid = 1; ld_word = '1;
        repeat (5) tick();
        ld_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("lrst_ld_ready", ld_ready, 1'b0);
        chk1("lrst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk1("lrst_no_output", out_valid, 1'b0);

        // Random stress against the model
        m_building = 0; m_holding = 0; m_is_load = 0;
        m_pend = 0; m_wcnt = 0; m_acc = '0; m_hold = '0;
        produced = 0; consumed = 0; accepted = 0;
        for (int cyc = 0; accepted < 10000 && cyc < 80000; cyc++) begin
            ins_valid = ($urandom_range(0, 3) != 0);
            d_in = ($urandom_range(0, 39) == 0);
            ins = 3'($urandom);
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_word = {$urandom, $urandom};
            for (int b = 0; b < NS; b++) begin
                src_valid[b] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) set_src(b, rand_wide());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle_model();
        end
        chk("stress_ops", W'(accepted), W'(10000));

        ins_valid = 0; d_in = 0;
        out_ready = 1; src_valid = '1; ld_valid = 1;
        for (int c = 0; c < 100; c++) begin
            if (!(m_building || m_holding)) break;
            cycle_model();
        end
        ld_valid = 0; src_valid = '0; out_ready = 0;
        chk("stress_produced", W'(produced), W'(accepted));
        chk("stress_consumed", W'(consumed), W'(produced));
        chk1("stress_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
